queue_sensor_conditioner: RTL and testbench
===========================================

Name: queue_sensor_conditioner

Overview:
Front-end stage directly upstream of the queue manager's up/down people counter.
- Takes the raw, asynchronous, bouncy entry/exit photo-sensor levels and synchronises and debounces them.
- Converts each qualified beam-break into exactly one single-cycle pulse on sensor_start / sensor_end.
- Gates those pulses with the counter's Full_flag / Empty_flag so rejected events never reach the counter, and counts rejected entries for the display/ops logic.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive stable synchronised samples required to accept a level change; legal range 1..255.
- SYNC_STAGES, 2: synchroniser depth per raw input; minimum 2.
- BLK_W, 8: width of the saturating blocked-entry counter.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- sensor_front_raw  in  1  raw entry-gate beam-break level (1 = beam broken), asynchronous.
- sensor_back_raw  in  1  raw exit/teller beam-break level, asynchronous.
- Full_flag  in  1  queue full, from the people counter.
- Empty_flag  in  1  queue empty, from the people counter.
- sensor_start  out  1  one-cycle qualified entry pulse to the counter.
- sensor_end  out  1  one-cycle qualified exit pulse to the counter.
- entry_blocked  out  1  one-cycle pulse: qualified entry suppressed because Full_flag was high.
- blocked_count  out  BLK_W  saturating count of entry_blocked pulses.

Behaviour:
- Reset: all flops are asynchronously cleared while RESET_N = 0.
  - Synchroniser stages = 0, FSMs = IDLE, debounce counters = 0.
  - sensor_start, sensor_end, entry_blocked = 0; blocked_count = 0.
- Synchroniser: SYNC_STAGES-flop chain per raw input. Only the last stage (s) feeds the FSM.
- Per-channel debounce FSM. Counter width = clog2(DEBOUNCE_CYCLES) (minimum 1 bit).
  - IDLE: s=1 -> ARM, cnt=0.
  - ARM: s=0 -> IDLE. Else if cnt==DEBOUNCE_CYCLES-1 -> HIGH and assert rise for one cycle. Else cnt++.
  - HIGH: s=0 -> DISARM, cnt=0.
  - DISARM: s=1 -> HIGH, with no new rise. Else if cnt==DEBOUNCE_CYCLES-1 -> IDLE. Else cnt++.
  - One rise per beam-break regardless of break duration. A glitch shorter than DEBOUNCE_CYCLES synchronised samples produces nothing.
- Latency: raw input first sampled high at edge k and held stable -> rise registered at edge k+SYNC_STAGES+DEBOUNCE_CYCLES. With defaults, the output is high in the cycle after edge k+6.
- Gating, all outputs registered:
  - At the edge where the front FSM enters HIGH: sensor_start <= ~Full_flag and entry_blocked <= Full_flag.
  - At the edge where the back FSM enters HIGH: sensor_end <= ~Empty_flag. A suppressed exit is silently dropped.
  - Flags are sampled at that same edge only; a flag change later in the beam-break has no effect.
- Simultaneous events: front and back channels are fully independent. Both pulses may assert in the same cycle; arbitration is the counter's job.
- blocked_count: increments on each entry_blocked pulse and saturates at 2^BLK_W-1 (no wrap). It is cleared only by reset.
- Reset mid-operation: any in-progress ARM/DISARM is abandoned and no pulse is emitted.
- Reset release with a beam already broken: a sensor held high across reset release produces one rise after SYNC_STAGES+DEBOUNCE_CYCLES cycles. This is the defined behaviour.
- Outputs are never high for more than one consecutive cycle per event.

Decomposition:
- Shared package queue_pkg:
  - debounce state enum (IDLE, ARM, HIGH, DISARM), 2-bit encoding.
  - default DEBOUNCE_CYCLES and SYNC_STAGES constants.
  - BLK_W default.
- Sub-module queue_sensor_debounce:
  - contains the synchroniser, counter and FSM, with output rise.
  - instantiated twice (front, back).
  - The top level holds only the flag gating, the output registers and blocked_count.

Test Plan:
- Clean entry, defaults, Full_flag=0: front_raw 0->1 sampled at edge 10, held 20 cycles -> sensor_start high only in the cycle after edge 16; sensor_end, entry_blocked stay 0.
- Bounce rejection: front_raw pulses high for 3 cycles, low for 2, then stable high -> exactly one sensor_start, at 6 edges after the start of the stable-high run; no pulse from the 3-cycle burst.
- Full gating:
  - Full_flag=1 at rise edge -> sensor_start=0, entry_blocked=1 for one cycle, blocked_count 0->1.
  - 300 blocked entries -> blocked_count=255.
- Empty gating: Empty_flag=1 with back break -> sensor_end=0. With Empty_flag=0, a break lasting 50 cycles with bounce on release -> exactly one sensor_end.
- Simultaneous: front and back raw rise on the same edge, flags 0 -> sensor_start and sensor_end both high in the same cycle, 6 edges later.
- Reset: RESET_N low during ARM -> all outputs 0, no pulse after release while raw low. Raw held high through reset release -> one sensor_start 6 edges after release.

Source files
------------

// File: rtl/queue_pkg.sv
// Shared types and defaults for the queue sensor front-end: debounce state
// encoding, parameter defaults and the debounce counter width helper.
package queue_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARM    = 2'd1,
        HIGH   = 2'd2,
        DISARM = 2'd3
    } db_state_e;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_BLK_W           = 8;

    // A one-cycle debounce still needs a 1-bit counter to compare against zero.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/queue_sensor_conditioner_if.sv
// Sensor/flag/pulse bundle between the photo sensors, the people counter and
// the conditioner.
interface queue_sensor_conditioner_if
    import queue_pkg::*;
#(
    parameter int BLK_W = DEF_BLK_W
);
    logic             sensor_front_raw;
    logic             sensor_back_raw;
    logic             Full_flag;
    logic             Empty_flag;
    logic             sensor_start;
    logic             sensor_end;
    logic             entry_blocked;
    logic [BLK_W-1:0] blocked_count;

    modport slave (
        input  sensor_front_raw, sensor_back_raw, Full_flag, Empty_flag,
        output sensor_start, sensor_end, entry_blocked, blocked_count
    );

    modport master (
        output sensor_front_raw, sensor_back_raw, Full_flag, Empty_flag,
        input  sensor_start, sensor_end, entry_blocked, blocked_count
    );
endinterface

// File: rtl/queue_sensor_debounce.sv
// One sensor channel: synchroniser, debounce counter and 4-state FSM that
// emits a single combinational rise on the ARM->HIGH transition.
module queue_sensor_debounce
    import queue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic i_raw,
    output logic o_rise
);
    localparam int             CNT_W   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_e              r_state, w_state_nxt;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
    logic                   w_s;
    logic                   w_rise;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync  <= '0;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_raw};
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: if (w_s) begin
                w_state_nxt = ARM;
                w_cnt_nxt   = '0;
            end
            ARM: begin
                if (!w_s)                 w_state_nxt = IDLE;
                else if (r_cnt == CNT_MAX) w_state_nxt = HIGH;
                else                      w_cnt_nxt   = r_cnt + 1'b1;
            end
            HIGH: if (!w_s) begin
                w_state_nxt = DISARM;
                w_cnt_nxt   = '0;
            end
            // Beam re-made during release bounce returns to HIGH without a new rise.
            DISARM: begin
                if (w_s)                  w_state_nxt = HIGH;
                else if (r_cnt == CNT_MAX) w_state_nxt = IDLE;
                else                      w_cnt_nxt   = r_cnt + 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_rise = (r_state == ARM) && w_s && (r_cnt == CNT_MAX);
    end

    assign o_rise = w_rise;

endmodule

// File: rtl/queue_sensor_conditioner.sv
// Debounces entry/exit sensors and gates the resulting pulses with the
// counter's Full/Empty flags; counts entries rejected while full.
module queue_sensor_conditioner
    import queue_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int BLK_W           = DEF_BLK_W
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    queue_sensor_conditioner_if.slave    bus
);
    localparam int NUM_CH = 2;  // [0] front/entry, [1] back/exit

    logic [NUM_CH-1:0] w_raw;
    logic [NUM_CH-1:0] w_rise;
    logic              w_blk;
    logic              r_start;
    logic              r_end;
    logic              r_blocked;
    logic [BLK_W-1:0]  r_blk_cnt;

    assign w_raw = {bus.sensor_back_raw, bus.sensor_front_raw};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        queue_sensor_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .SYNC_STAGES     (SYNC_STAGES)
        ) u_deb (
            .CLK     (CLK),
            .RESET_N (RESET_N),
            .i_raw   (w_raw[g]),
            .o_rise  (w_rise[g])
        );
    end

    // Flags are only looked at on the rise edge itself.
    assign w_blk = w_rise[0] & bus.Full_flag;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_start   <= 1'b0;
            r_end     <= 1'b0;
            r_blocked <= 1'b0;
            r_blk_cnt <= '0;
        end else begin
            r_start   <= w_rise[0] & ~bus.Full_flag;
            r_end     <= w_rise[1] & ~bus.Empty_flag;
            r_blocked <= w_blk;
            if (w_blk && (r_blk_cnt != {BLK_W{1'b1}}))
                r_blk_cnt <= r_blk_cnt + 1'b1;
        end
    end

    assign bus.sensor_start  = r_start;
    assign bus.sensor_end    = r_end;
    assign bus.entry_blocked = r_blocked;
    assign bus.blocked_count = r_blk_cnt;

endmodule

// File: tb/tb_queue_sensor_conditioner.sv
// Directed bench for queue_sensor_conditioner: clean/bounced entries, flag
// gating, blocked-count saturation, simultaneous events and reset cases.
module tb_queue_sensor_conditioner;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;

    queue_sensor_conditioner_if #(.BLK_W(8)) bus();

    queue_sensor_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .SYNC_STAGES     (2),
        .BLK_W           (8)
    ) dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start, n_end, n_blk, n_dbl;
    int last_start, last_end, last_blk;
    logic p_start, p_end, p_blk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_start = 0; n_end = 0; n_blk = 0; n_dbl = 0;
        last_start = -1; last_end = -1; last_blk = -1;
        p_start = 0; p_end = 0; p_blk = 0;
    endtask

    // Advance n clocks, observing outputs 1 time unit after each rising edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            cyc++;
            if (bus.sensor_start) begin n_start++; last_start = cyc; if (p_start) n_dbl++; end
            if (bus.sensor_end) begin n_end++; last_end = cyc; if (p_end) n_dbl++; end
            if (bus.entry_blocked) begin n_blk++; last_blk = cyc; if (p_blk) n_dbl++; end
            p_start = bus.sensor_start; p_end = bus.sensor_end; p_blk = bus.entry_blocked;
        end
    endtask

    int c0, c1;

    initial begin
        bus.sensor_front_raw = 0; bus.sensor_back_raw = 0;
        bus.Full_flag = 0; bus.Empty_flag = 0;
        clr();
        run(3);
        chk("rst_start", 32'(bus.sensor_start), 0);
        chk("rst_cnt", 32'(bus.blocked_count), 0);
        RESET_N = 1;
        run(5);

        // Clean entry: rise registered 6 edges after the first sampling edge.
        clr(); c0 = cyc; bus.sensor_front_raw = 1;
        run(20); bus.sensor_front_raw = 0; run(15);
        chk("clean_n_start", n_start, 1);
        chk("clean_when", last_start, c0 + 7);
        chk("clean_n_end", n_end, 0);
        chk("clean_n_blk", n_blk, 0);

        // 3-high / 2-low burst then stable high.
        clr(); c0 = cyc; bus.sensor_front_raw = 1;
        run(3); bus.sensor_front_raw = 0;
        run(2); c1 = cyc; bus.sensor_front_raw = 1;
        run(20); bus.sensor_front_raw = 0; run(15);
        chk("bounce_n_start", n_start, 1);
        chk("bounce_when", last_start, c1 + 7);

        // Entry while full.
        clr(); bus.Full_flag = 1; c0 = cyc; bus.sensor_front_raw = 1;
        run(10); bus.sensor_front_raw = 0; run(12);
        chk("full_n_start", n_start, 0);
        chk("full_n_blk", n_blk, 1);
        chk("full_when", last_blk, c0 + 7);
        chk("full_cnt1", 32'(bus.blocked_count), 1);

        // 299 further blocked entries saturate the counter at 255.
        for (int i = 0; i < 299; i++) begin
            bus.sensor_front_raw = 1; run(9);
            bus.sensor_front_raw = 0; run(10);
        end
        chk("sat_n_blk", n_blk, 300);
        chk("sat_cnt", 32'(bus.blocked_count), 255);
        chk("sat_n_start", n_start, 0);
        bus.Full_flag = 0;

        // Exit while empty is dropped silently.
        clr(); bus.Empty_flag = 1; bus.sensor_back_raw = 1;
        run(10); bus.sensor_back_raw = 0; run(12);
        chk("empty_n_end", n_end, 0);
        chk("empty_n_blk", n_blk, 0);

        // Long exit with release bounce; later Empty change must not matter.
        clr(); bus.Empty_flag = 0; c0 = cyc; bus.sensor_back_raw = 1;
        run(25); bus.Empty_flag = 1; run(25); bus.Empty_flag = 0;
        bus.sensor_back_raw = 0; run(2);
        bus.sensor_back_raw = 1; run(2);
        bus.sensor_back_raw = 0; run(1);
        bus.sensor_back_raw = 1; run(3);
        bus.sensor_back_raw = 0; run(20);
        chk("long_n_end", n_end, 1);
        chk("long_when", last_end, c0 + 7);

        // Simultaneous entry and exit.
        clr(); c0 = cyc; bus.sensor_front_raw = 1; bus.sensor_back_raw = 1;
        run(12); bus.sensor_front_raw = 0; bus.sensor_back_raw = 0; run(15);
        chk("sim_start_when", last_start, c0 + 7);
        chk("sim_end_when", last_end, c0 + 7);
        chk("sim_counts", n_start + n_end, 2);

        // Reset during ARM: no pulse survives, counter cleared.
        clr(); bus.sensor_front_raw = 1;
        run(4); RESET_N = 0; bus.sensor_front_raw = 0;
        run(2);
        chk("rarm_start", 32'(bus.sensor_start), 0);
        chk("rarm_blk", 32'(bus.entry_blocked), 0);
        chk("rarm_cnt", 32'(bus.blocked_count), 0);
        RESET_N = 1; run(15);
        chk("rarm_n_start", n_start, 0);

        // Beam held across reset release gives exactly one entry.
        clr(); bus.sensor_front_raw = 1; RESET_N = 0;
        run(3); c0 = cyc; RESET_N = 1;
        run(20); bus.sensor_front_raw = 0; run(15);
        chk("rhold_n_start", n_start, 1);
        chk("rhold_when", last_start, c0 + 7);

        chk("no_double_pulse", n_dbl, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
